// File: rtl/canny_frame_sequencer.sv
// Frame sequencer for a Canny edge pipeline: raster-order image reads,
// pad-pixel flush, beat counting, completion and error reporting.
module canny_frame_sequencer #(
    parameter int unsigned IMG_W   = 512,
    parameter int unsigned IMG_H   = 512,
    parameter int unsigned PAD_MAX = 2048,
    parameter int unsigned AW      = 18
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          start,
    input  logic          abort,
    input  logic          hold,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic [7:0]    pixel_in,
    output logic          pixel_in_valid,
    input  logic          edge_out_valid,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic          overrun_err,
    output logic [AW-1:0] out_count
);

    localparam int unsigned N  = IMG_W * IMG_H;
    localparam int unsigned FW = $clog2(PAD_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] out_count_q, out_count_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic          rd_pend_q, rd_pend_d;
    logic [7:0]    pix_q, pix_d;
    logic          pix_vld_q, pix_vld_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_fire;
    logic          count_hit;
    logic          busy_now;

    // Next-state, counters, error flags and registered output values
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_count_d = out_count_q;
        flush_cnt_d = flush_cnt_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;
        rd_fire     = 1'b0;
        count_hit   = 1'b0;
        busy_now    = (state_q == S_FEED) || (state_q == S_FLUSH);

        // Tail beats count only while streaming and below a full frame
        if (edge_out_valid) begin
            if (busy_now && (out_count_q != AW'(N))) begin
                out_count_d = out_count_q + AW'(1);
                count_hit   = (out_count_q == AW'(N - 1));
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (abort) begin
            state_d   = S_IDLE;
            rd_addr_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state_d     = S_FEED;
                        rd_addr_d   = '0;
                        out_count_d = '0;
                        flush_cnt_d = '0;
                        timeout_d   = 1'b0;
                        overrun_d   = 1'b0;
                    end
                end
                S_FEED: begin
                    if (!hold) begin
                        rd_fire   = 1'b1;
                        rd_addr_d = rd_addr_q + AW'(1);
                        if (rd_addr_q == AW'(N - 1)) begin
                            state_d = S_FLUSH;
                        end
                    end
                    // Completion outranks the final-read transition
                    if (count_hit) begin
                        state_d = S_DONE;
                    end
                end
                S_FLUSH: begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                    if (count_hit) begin
                        state_d = S_DONE;
                    end else if (flush_cnt_q == FW'(PAD_MAX - 1)) begin
                        state_d   = S_ERR;
                        timeout_d = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d    = (state_d == S_FEED) || (state_d == S_FLUSH);
        done_d    = (state_d == S_DONE);
        rd_pend_d = rd_fire;
        // Image data has priority over pads; nothing leaves once streaming ends
        pix_vld_d = busy_d && (rd_pend_q || (state_d == S_FLUSH));
        pix_d     = (busy_d && rd_pend_q) ? mem_rd_data : 8'd0;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            out_count_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            pix_q       <= 8'd0;
            pix_vld_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_count_q <= out_count_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            rd_pend_q   <= rd_pend_d;
            pix_q       <= pix_d;
            pix_vld_q   <= pix_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Read strobe follows hold in the same cycle; everything else is registered
    assign mem_rd_en      = rd_fire;
    assign mem_addr       = rd_addr_q;
    assign pixel_in       = pix_q;
    assign pixel_in_valid = pix_vld_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout_err    = timeout_q;
    assign overrun_err    = overrun_q;
    assign out_count      = out_count_q;

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Directed self-checking bench for canny_frame_sequencer on a 4x4 frame.
module tb_canny_frame_sequencer;

    localparam int unsigned AW = 18;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start;
    logic          abort;
    logic          hold;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data = 8'd0;
    logic [7:0]    pixel_in;
    logic          pixel_in_valid;
    logic          edge_out_valid;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic          overrun_err;
    logic [AW-1:0] out_count;

    int n_tests = 0;
    int n_fail  = 0;

    canny_frame_sequencer #(
        .IMG_W  (4),
        .IMG_H  (4),
        .PAD_MAX(20),
        .AW     (AW)
    ) dut (
        .clk           (clk),
        .rstN          (rstN),
        .start         (start),
        .abort         (abort),
        .hold          (hold),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .pixel_in      (pixel_in),
        .pixel_in_valid(pixel_in_valid),
        .edge_out_valid(edge_out_valid),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err),
        .out_count     (out_count)
    );

    always #5 clk = ~clk;

    // Memory returns the low address byte one cycle after each read
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_addr[7:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Read schedule with hold in cycles 5..7
    function automatic bit t2_rd(input int c);
        return (c >= 1 && c <= 4) || (c >= 8 && c <= 19);
    endfunction

    function automatic int t2_addr(input int c);
        return (c <= 4) ? c - 1 : c - 4;
    endfunction

    initial begin
        rstN = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; edge_out_valid = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_pix", 32'(pixel_in), 32'd0);
        check("rst_pvld", 32'(pixel_in_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tmo", 32'(timeout_err), 32'd0);
        check("rst_ovr", 32'(overrun_err), 32'd0);
        check("rst_cnt", 32'(out_count), 32'd0);
        next_cycle();
        rstN = 1'b1;

        // Full frame, 16 beats during flush
        for (int c = 0; c <= 34; c++) begin
            start = (c == 0);
            edge_out_valid = (c >= 17 && c <= 32);
            @(negedge clk);
            check("t1_rd_en", 32'(mem_rd_en), 32'(c >= 1 && c <= 16));
            if (c >= 1 && c <= 16) check("t1_addr", 32'(mem_addr), 32'(c - 1));
            check("t1_pvld", 32'(pixel_in_valid), 32'(c >= 3 && c <= 32));
            if (c >= 3 && c <= 32) check("t1_pix", 32'(pixel_in), 32'((c <= 18) ? c - 3 : 0));
            check("t1_busy", 32'(busy), 32'(c >= 1 && c <= 32));
            check("t1_done", 32'(done), 32'(c == 33));
            if (c == 33) check("t1_cnt", 32'(out_count), 32'd16);
            next_cycle();
        end
        edge_out_valid = 1'b1;
        @(negedge clk);
        check("ovr_before", 32'(overrun_err), 32'd0);
        next_cycle();
        edge_out_valid = 1'b0;
        @(negedge clk);
        check("ovr_after", 32'(overrun_err), 32'd1);
        check("ovr_cnt", 32'(out_count), 32'd16);
        next_cycle();

        // Count reaches N on the final-read cycle: completion wins
        for (int c = 0; c <= 18; c++) begin
            start = (c == 0);
            edge_out_valid = (c >= 1 && c <= 16);
            @(negedge clk);
            check("t5_rd_en", 32'(mem_rd_en), 32'(c >= 1 && c <= 16));
            check("t5_done", 32'(done), 32'(c == 17));
            if (c == 17) begin
                check("t5_busy", 32'(busy), 32'd0);
                check("t5_pvld", 32'(pixel_in_valid), 32'd0);
                check("t5_cnt", 32'(out_count), 32'd16);
                check("t5_ovr", 32'(overrun_err), 32'd0);
            end
            next_cycle();
        end
        start = 1'b0; edge_out_valid = 1'b0;

        // Hold gap, only 10 beats -> flush timeout, then abort from ERR
        for (int c = 0; c <= 41; c++) begin
            start = (c == 0);
            hold = (c >= 5 && c <= 7);
            edge_out_valid = (c >= 20 && c <= 29);
            abort = (c == 41);
            @(negedge clk);
            check("t2_rd_en", 32'(mem_rd_en), 32'(t2_rd(c)));
            if (t2_rd(c)) check("t2_addr", 32'(mem_addr), 32'(t2_addr(c)));
            if (c >= 2 && c <= 39) begin
                check("t2_pvld", 32'(pixel_in_valid), 32'(t2_rd(c - 2) || c >= 22));
                check("t2_pix", 32'(pixel_in), 32'(t2_rd(c - 2) ? t2_addr(c - 2) : 0));
            end
            check("t2_done", 32'(done), 32'd0);
            check("t2_busy", 32'(busy), 32'(c >= 1 && c <= 39));
            check("t2_tmo", 32'(timeout_err), 32'(c >= 40));
            if (c == 40) begin
                check("t2_pvld_err", 32'(pixel_in_valid), 32'd0);
                check("t2_cnt", 32'(out_count), 32'd10);
            end
            next_cycle();
        end
        abort = 1'b0; hold = 1'b0; edge_out_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_tmo_kept", 32'(timeout_err), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        next_cycle();

        // Abort mid-feed, restart at 0, then reset mid-frame
        for (int c = 0; c <= 19; c++) begin
            start = (c == 0 || c == 12);
            abort = (c == 8);
            rstN = !(c == 15);
            @(negedge clk);
            if (c >= 1 && c <= 7) begin
                check("t3_rd_en", 32'(mem_rd_en), 32'd1);
                check("t3_addr", 32'(mem_addr), 32'(c - 1));
            end
            if (c >= 3 && c <= 8) check("t3_pix", 32'(pixel_in), 32'(c - 3));
            if (c == 1) check("t3_tmo_clr", 32'(timeout_err), 32'd0);
            if (c >= 9 && c <= 12) begin
                check("t3_rd_off", 32'(mem_rd_en), 32'd0);
                check("t3_pvld_off", 32'(pixel_in_valid), 32'd0);
                check("t3_busy_off", 32'(busy), 32'd0);
            end
            if (c == 13 || c == 14) begin
                check("t3_restart_rd", 32'(mem_rd_en), 32'd1);
                check("t3_restart_addr", 32'(mem_addr), 32'(c - 13));
            end
            if (c == 16) begin
                check("t4_addr", 32'(mem_addr), 32'd0);
                check("t4_pix", 32'(pixel_in), 32'd0);
                check("t4_busy", 32'(busy), 32'd0);
                check("t4_cnt", 32'(out_count), 32'd0);
                check("t4_done", 32'(done), 32'd0);
            end
            if (c >= 16) begin
                check("t4_rd_en", 32'(mem_rd_en), 32'd0);
                check("t4_pvld", 32'(pixel_in_valid), 32'd0);
            end
            next_cycle();
        end
        rstN = 1'b1; start = 1'b0; abort = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
